// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial receiver (start, data, optional even parity, stop)
module serial_frame_rx #(
    parameter int DATA_W    = 4,
    parameter int PARITY_EN = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_buf;
    logic [4:0]        bit_cnt;
    logic              par_bit;
    logic [DATA_W-1:0] shifted;
    logic              par_bad;

    assign shifted = (LSB_FIRST != 0) ? {serial_in, shift_buf[DATA_W-1:1]}
                                      : {shift_buf[DATA_W-2:0], serial_in};
    assign par_bad = (PARITY_EN != 0) && (par_bit != ^shift_buf);

    // Frame FSM; busy stays up for the cycle carrying the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_buf  <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= state != IDLE;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_buf <= shifted;
                        bit_cnt   <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(DATA_W - 1))
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_bit <= serial_in;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b1;
                        if (serial_in) begin
                            data_out   <= shift_buf;
                            data_valid <= 1'b1;
                            parity_err <= par_bad;
                            if (!par_bad)
                                frame_cnt <= frame_cnt + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver that sits directly downstream of the universal shift register's serial output. When the shift register runs in a shift mode, this block reassembles the bit stream into words, one bit per qualified clock. Frames are: start bit (0), DATA_W data bits, an optional even-parity bit, and a stop bit (1). The block reports received words, parity and framing errors, and a running count of good frames.

## Interface
- DATA_W, 4: data bits per frame (2..16).
- PARITY_EN, 1: 1 = a parity bit follows the data, 0 = no parity bit.
- LSB_FIRST, 1: 1 = the first data bit lands in data_out[0]; 0 = the first data bit lands in data_out[DATA_W-1].
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial line; driven from the shift register serial output.
- bit_en  input  1  sample qualifier; serial_in is sampled only on rising edges where bit_en=1.
- data_out  output  DATA_W  last received word; holds its value between frames.
- data_valid  output  1  one-cycle pulse when a frame with a good stop bit completes.
- parity_err  output  1  one-cycle pulse, coincident with data_valid, when parity mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever the state is not IDLE.
- frame_cnt  output  8  count of frames with good stop and good parity; wraps 255 -> 0.

## Operation
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - data_out, frame_cnt, the shift buffer and the bit counter clear to 0.
  - data_valid, parity_err, frame_err and busy are 0.
- States: IDLE, DATA, PARITY, STOP. Transitions are evaluated only on edges with bit_en=1. With bit_en=0 the block holds all state; the pulse outputs still deassert after one cycle.
- IDLE:
  - serial_in=0 sampled -> DATA, bit counter = 0.
  - serial_in=1 -> stay in IDLE.
- DATA:
  - Each sample shifts into the buffer. With LSB_FIRST=1 the buffer shifts right and the new bit enters at [DATA_W-1]; with LSB_FIRST=0 it shifts left and the new bit enters at [0].
  - After DATA_W samples -> PARITY if PARITY_EN=1, else STOP.
- PARITY: captures the sampled bit -> STOP. Expected bit = XOR of the buffer (even parity over data plus parity bit).
- STOP sample = 1:
  - data_out <= buffer; data_valid=1.
  - parity_err=1 if PARITY_EN=1 and the captured bit differs from the expected bit.
  - frame_cnt increments only if parity_err=0.
  - -> IDLE.
- STOP sample = 0:
  - frame_err=1; data_out and frame_cnt unchanged; data_valid=0.
  - -> IDLE. The 0 stop bit is never treated as a start bit.
- Pulses are registered; data_valid, parity_err and frame_err are never asserted in consecutive cycles from a single frame.
- frame_cnt arithmetic is 8-bit unsigned modulo 256.

## Timing
- With bit_en held at 1 and PARITY_EN=1, DATA_W=4, the start bit is sampled at edge E0:
  - data bits at E1..E4, parity at E5, stop at E6.
  - data_valid is high in the cycle following E6. busy is high from after E0 through the cycle following E6.
- Without parity, the stop bit is sampled at E(DATA_W+1).
- Back-to-back frames: a start bit sampled at the first bit_en edge after the stop edge is accepted. Zero idle bits are required.
- Gaps in bit_en of any length are allowed anywhere in a frame and must not change the result.
- Reset asserted mid-frame aborts the frame: no pulse is emitted and the partial data is discarded. The first frame after reset release decodes normally.

## Test plan
- Defaults, bit_en=1, serial 0,1,1,1,0,1,1 (start, LSB-first 0111, parity 1, stop) -> data_out=4'b0111, data_valid pulse 1 cycle after the stop edge, parity_err=0, frame_cnt=1.
- Same frame with parity bit 0 -> data_out=4'b0111, data_valid=1 and parity_err=1 in the same cycle, frame_cnt stays 0.
- Serial 0,0,1,0,0,1,0 (stop bit 0) -> frame_err pulse, data_valid=0, data_out keeps its previous value. The next start bit is accepted only after a later 0 is sampled in IDLE.
- Frame of data 4'b0010 sent with bit_en low for 3 cycles between every bit -> data_out=4'b0010, one data_valid pulse, busy high throughout the frame.
- Reset pulse after the second data bit, then a clean 4'b1010 frame -> no pulse from the aborted frame; data_out=4'b1010, frame_cnt=1.
- LSB_FIRST=0, PARITY_EN=0, serial 0,1,0,0,0,1 -> data_out=4'b1000. Also send 256 good frames -> frame_cnt wraps to 0.
